// File: rtl/control_sequencer.sv
// Control-unit sequencer: fetch (T0-T2) then execute (T3-T6) for three-operand, MUL/DIV and illegal ops.
// Optional build macro SEQ_SINGLE_STEP_EN adds a `step` input that gates every non-IDLE transition.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] IR,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  GP_addr,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        incPC,
  output logic        MDR_read,
  output logic [3:0]  ALU_op,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [4:0] SEL_ZHI = 5'b10010;
  localparam logic [4:0] SEL_ZLO = 5'b10011;
  localparam logic [4:0] SEL_PC  = 5'b10100;
  localparam logic [4:0] SEL_MDR = 5'b10101;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0110;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  state_t     state;
  state_t     state_next;
  logic       illegal_q;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic [3:0] op;
  logic       is_illegal;
  logic       is_muldiv;
  logic       advance;
  logic       unused_ir_bits;

  assign ra             = IR[26:23];
  assign rb             = IR[22:19];
  assign rc             = IR[18:15];
  assign op             = IR[30:27];
  assign is_illegal     = IR[31];
  assign is_muldiv      = !is_illegal && ((op == OP_MUL) || (op == OP_DIV));
  assign unused_ir_bits = ^IR[14:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Sticky until reset; the T3 decode term below makes it visible within T3 itself.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                                illegal_q <= 1'b0;
    else if ((state == T3) && is_illegal)     illegal_q <= 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (run) state_next = T0;
      T0:   state_next = T1;
      T1:   state_next = T2;
      T2:   state_next = T3;
      T3:   state_next = is_illegal ? (run ? T0 : IDLE) : T4;
      T4:   state_next = T5;
      T5:   state_next = is_muldiv ? T6 : (run ? T0 : IDLE);
      T6:   state_next = run ? T0 : IDLE;
      default: state_next = IDLE;
    endcase
    if ((state != IDLE) && !advance) state_next = state;
  end

  // Moore decode of state and IR fields.
  always_comb begin
    BusDataSelect = 5'd0;
    GP_addr       = 4'd0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    ALU_op        = 4'd0;
    done          = 1'b0;
    busy          = (state != IDLE);
    illegal       = illegal_q || ((state == T3) && is_illegal);
    case (state)
      T0: begin
        BusDataSelect = SEL_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        e_Z           = 1'b1;
      end
      T1: begin
        BusDataSelect = SEL_ZLO;
        e_PC          = 1'b1;
        MDR_read      = 1'b1;
        e_MDR         = 1'b1;
      end
      T2: begin
        BusDataSelect = SEL_MDR;
        e_IR          = 1'b1;
      end
      T3: begin
        if (is_illegal) begin
          done = 1'b1;
        end else begin
          BusDataSelect = is_muldiv ? 5'(ra) : 5'(rb);
          e_Y           = 1'b1;
        end
      end
      T4: begin
        BusDataSelect = is_muldiv ? 5'(rb) : 5'(rc);
        e_Z           = 1'b1;
        ALU_op        = op;
      end
      T5: begin
        BusDataSelect = SEL_ZLO;
        if (is_muldiv) begin
          e_LO = 1'b1;
        end else begin
          GP_addr = ra;
          e_GP    = 1'b1;
          done    = 1'b1;
        end
      end
      T6: begin
        BusDataSelect = SEL_ZHI;
        e_HI          = 1'b1;
        done          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: per-cycle expected output words from a table,
// plus hand sequences for asynchronous clear and (when SEQ_SINGLE_STEP_EN is defined) single-stepping.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic [31:0] IR;
  logic [4:0]  BusDataSelect;
  logic [3:0]  GP_addr;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        incPC, MDR_read;
  logic [3:0]  ALU_op;
  logic        busy, done, illegal;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .IR(IR), .BusDataSelect(BusDataSelect), .GP_addr(GP_addr),
    .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .incPC(incPC), .MDR_read(MDR_read),
    .ALU_op(ALU_op), .busy(busy), .done(done), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [8:0] EN_PC  = 9'h100;
  localparam logic [8:0] EN_IR  = 9'h080;
  localparam logic [8:0] EN_Y   = 9'h040;
  localparam logic [8:0] EN_Z   = 9'h020;
  localparam logic [8:0] EN_HI  = 9'h010;
  localparam logic [8:0] EN_LO  = 9'h008;
  localparam logic [8:0] EN_MDR = 9'h004;
  localparam logic [8:0] EN_MAR = 9'h002;
  localparam logic [8:0] EN_GP  = 9'h001;
  localparam logic [4:0] S_ZHI  = 5'b10010;
  localparam logic [4:0] S_ZLO  = 5'b10011;
  localparam logic [4:0] S_PC   = 5'b10100;
  localparam logic [4:0] S_MDR  = 5'b10101;
  localparam logic [26:0] FULL   = 27'h7FF_FFFF;
  localparam logic [26:0] NO_ALU = 27'h7FF_FFF0;

  localparam logic [31:0] IR_DIV = {5'b00110, 4'd2, 4'd6, 4'd0, 15'd0};
  localparam logic [31:0] IR_ADD = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] IR_ILL = 32'h8000_0000;

  // {busy, done, illegal, incPC, MDR_read, enables[8:0], bus[4:0], gp[3:0], alu[3:0]}
  logic [26:0] outv;
  assign outv = {busy, done, illegal, incPC, MDR_read,
                 e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
                 BusDataSelect, GP_addr, ALU_op};

  typedef struct {
    logic [95:0] name;
    logic        run;
    logic [31:0] ir;
    logic [26:0] exp;
    logic [26:0] mask;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic logic [26:0] mk(logic b, logic d, logic il, logic inc, logic mr,
                                     logic [8:0] en, logic [4:0] bus, logic [3:0] gp,
                                     logic [3:0] alu);
    return {b, d, il, inc, mr, en, bus, gp, alu};
  endfunction

  task automatic add(input logic [95:0] name, input logic r, input logic [31:0] ir,
                     input logic [26:0] exp, input logic [26:0] mask);
    vec_t v;
    v.name = name; v.run = r; v.ir = ir; v.exp = exp; v.mask = mask;
    vecs.push_back(v);
  endtask

  task automatic check(input logic [95:0] name, input logic [26:0] exp, input logic [26:0] mask);
    tests++;
    if ((outv & mask) !== (exp & mask)) begin
      failed++;
      $display("FAIL %0s: got %07h expected %07h (mask %07h) at %0t", name, outv, exp, mask, $time);
    end
  endtask

  initial begin
    // Fetch rows shared by every instruction (illegal flag clear).
    add("idle0",   1'b0, IR_DIV, 27'd0, FULL);
    add("div_t0",  1'b1, IR_DIV, mk(1,0,0,1,0, EN_MAR|EN_Z,  S_PC,  4'd0, 4'd0), NO_ALU);
    add("div_t1",  1'b1, IR_DIV, mk(1,0,0,0,1, EN_PC|EN_MDR, S_ZLO, 4'd0, 4'd0), FULL);
    add("div_t2",  1'b1, IR_DIV, mk(1,0,0,0,0, EN_IR,        S_MDR, 4'd0, 4'd0), FULL);
    add("div_t3",  1'b1, IR_DIV, mk(1,0,0,0,0, EN_Y,         5'd2,  4'd0, 4'd0), FULL);
    add("div_t4",  1'b1, IR_DIV, mk(1,0,0,0,0, EN_Z,         5'd6,  4'd0, 4'h6), FULL);
    add("div_t5",  1'b1, IR_DIV, mk(1,0,0,0,0, EN_LO,        S_ZLO, 4'd0, 4'd0), FULL);
    add("div_t6",  1'b1, IR_DIV, mk(1,1,0,0,0, EN_HI,        S_ZHI, 4'd0, 4'd0), FULL);
    add("add_t0",  1'b1, IR_ADD, mk(1,0,0,1,0, EN_MAR|EN_Z,  S_PC,  4'd0, 4'd0), NO_ALU);
    add("add_t1",  1'b1, IR_ADD, mk(1,0,0,0,1, EN_PC|EN_MDR, S_ZLO, 4'd0, 4'd0), FULL);
    add("add_t2",  1'b1, IR_ADD, mk(1,0,0,0,0, EN_IR,        S_MDR, 4'd0, 4'd0), FULL);
    add("add_t3",  1'b0, IR_ADD, mk(1,0,0,0,0, EN_Y,         5'd2,  4'd0, 4'd0), FULL);
    add("add_t4",  1'b0, IR_ADD, mk(1,0,0,0,0, EN_Z,         5'd3,  4'd0, 4'h3), FULL);
    add("add_t5",  1'b0, IR_ADD, mk(1,1,0,0,0, EN_GP,        S_ZLO, 4'd1, 4'd0), FULL);
    add("add_idle",1'b0, IR_ADD, 27'd0, FULL);
    add("idle_hld",1'b0, IR_ADD, 27'd0, FULL);
    add("ill_t0",  1'b1, IR_ILL, mk(1,0,0,1,0, EN_MAR|EN_Z,  S_PC,  4'd0, 4'd0), NO_ALU);
    add("ill_t1",  1'b1, IR_ILL, mk(1,0,0,0,1, EN_PC|EN_MDR, S_ZLO, 4'd0, 4'd0), FULL);
    add("ill_t2",  1'b1, IR_ILL, mk(1,0,0,0,0, EN_IR,        S_MDR, 4'd0, 4'd0), FULL);
    add("ill_t3",  1'b0, IR_ILL, mk(1,1,1,0,0, 9'd0,         5'd0,  4'd0, 4'd0), FULL);
    add("ill_idle",1'b0, IR_ILL, mk(0,0,1,0,0, 9'd0,         5'd0,  4'd0, 4'd0), FULL);
    add("ill_hold",1'b0, IR_ADD, mk(0,0,1,0,0, 9'd0,         5'd0,  4'd0, 4'd0), FULL);
    add("ad2_t0",  1'b1, IR_ADD, mk(1,0,1,1,0, EN_MAR|EN_Z,  S_PC,  4'd0, 4'd0), NO_ALU);
    add("ad2_t1",  1'b1, IR_ADD, mk(1,0,1,0,1, EN_PC|EN_MDR, S_ZLO, 4'd0, 4'd0), FULL);
    add("ad2_t2",  1'b1, IR_ADD, mk(1,0,1,0,0, EN_IR,        S_MDR, 4'd0, 4'd0), FULL);
    add("ad2_t3",  1'b1, IR_ADD, mk(1,0,1,0,0, EN_Y,         5'd2,  4'd0, 4'd0), FULL);
    add("ad2_t4",  1'b1, IR_ADD, mk(1,0,1,0,0, EN_Z,         5'd3,  4'd0, 4'h3), FULL);

    clear = 1'b1;
    run   = 1'b1;
    IR    = IR_DIV;
`ifdef SEQ_SINGLE_STEP_EN
    step  = 1'b1;
`endif
    repeat (2) @(posedge clock);
    #1;
    check("reset", 27'd0, FULL);
    clear = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run = vecs[i].run;
      IR  = vecs[i].ir;
      @(posedge clock);
      #1;
      check(vecs[i].name, vecs[i].exp, vecs[i].mask);
    end

    // Asynchronous clear in the middle of T4: outputs must drop before the next edge.
    #2 clear = 1'b1;
    #1 check("clr_async", 27'd0, FULL);
    @(posedge clock);
    #1 check("clr_held", 27'd0, FULL);
    clear = 1'b0;
    run   = 1'b0;
    @(posedge clock);
    #1 check("clr_idle", 27'd0, FULL);

`ifdef SEQ_SINGLE_STEP_EN
    // Leaving IDLE ignores step; afterwards each advance needs step on the edge.
    step = 1'b0;
    run  = 1'b1;
    IR   = IR_ADD;
    @(posedge clock);
    #1 check("stp_t0", mk(1,0,0,1,0, EN_MAR|EN_Z, S_PC, 4'd0, 4'd0), NO_ALU);
    @(posedge clock);
    #1 check("stp_t0hld", mk(1,0,0,1,0, EN_MAR|EN_Z, S_PC, 4'd0, 4'd0), NO_ALU);
    step = 1'b1;
    @(posedge clock);
    #1 check("stp_t1", mk(1,0,0,0,1, EN_PC|EN_MDR, S_ZLO, 4'd0, 4'd0), FULL);
    step = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1 check("stp_t1hld", mk(1,0,0,0,1, EN_PC|EN_MDR, S_ZLO, 4'd0, 4'd0), FULL);
    end
    step = 1'b1;
    @(posedge clock);
    #1 check("stp_t2", mk(1,0,0,0,0, EN_IR, S_MDR, 4'd0, 4'd0), FULL);
    step = 1'b0;
    @(posedge clock);
    #1 check("stp_t2hld", mk(1,0,0,0,0, EN_IR, S_MDR, 4'd0, 4'd0), FULL);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: `clock` input 1, rising-edge clock; `clear` input 1, async active-high reset.
REQ-002 The remaining ports SHALL be as follows:
- `run` input 1: level request to execute instructions.
- `IR` input 32: instruction from the datapath IR.
- `BusDataSelect` output 5: bus source select.
- `GP_addr` output 4: general-purpose register file index.
- `e_PC`, `e_IR`, `e_Y`, `e_Z`, `e_HI`, `e_LO`, `e_MDR`, `e_MAR`, `e_GP` output 1 each: register load enables.
- `incPC` output 1: ALU computes PC+1.
- `MDR_read` output 1: MDR loads from Mdatain.
- `ALU_op` output 4: ALU operation code.
- `busy` output 1: not in IDLE.
- `done` output 1: one-cycle pulse in the last state of an instruction.
- `illegal` output 1: sticky illegal-opcode flag.

Function
REQ-003 The state register SHALL hold one of IDLE, T0, T1, T2, T3, T4, T5, T6 and SHALL advance only on the rising edge of `clock`.
REQ-004 All outputs SHALL be a pure Moore decode of the state register and `IR`, and SHALL hold constant for the full cycle of each state.
REQ-005 Bus select encoding SHALL be: 0-15 = R0-R15, 5'b10010 = Zhigh, 5'b10011 = Zlow, 5'b10100 = PC, 5'b10101 = MDR.
REQ-006 IR fields SHALL be: opcode = `IR[31:27]`, ra = `IR[26:23]`, rb = `IR[22:19]`, rc = `IR[18:15]`; `ALU_op` = `IR[30:27]` in T4.
REQ-007 Outside T0 and T4, `ALU_op` SHALL be 4'b0000; outside GP-write states, `GP_addr` SHALL be 0.
REQ-008 IDLE SHALL drive all enables 0 and `BusDataSelect` = 0; it SHALL go to T0 when `run` = 1.
REQ-009 T0 SHALL drive `BusDataSelect` = PC, `e_MAR` = 1, `incPC` = 1, `e_Z` = 1.
REQ-010 T1 SHALL drive `BusDataSelect` = Zlow, `e_PC` = 1, `MDR_read` = 1, `e_MDR` = 1.
REQ-011 T2 SHALL drive `BusDataSelect` = MDR, `e_IR` = 1; `IR` SHALL be considered valid from T3 onward.
REQ-012 In T3, if `IR[31]` = 1 (illegal), the sequencer SHALL set `illegal`, assert no enables, pulse `done`, and leave T3 per REQ-016.
REQ-013 For a three-operand op (`ALU_op` not 0101 MUL and not 0110 DIV), the sequencer SHALL:
- T3: `BusDataSelect` = rb, `e_Y` = 1.
- T4: `BusDataSelect` = rc, `e_Z` = 1.
- T5: `BusDataSelect` = Zlow, `GP_addr` = ra, `e_GP` = 1, `done` = 1.
- Skip T6.
REQ-014 For MUL/DIV (`ALU_op` 0101/0110), the sequencer SHALL:
- T3: `BusDataSelect` = ra, `e_Y` = 1.
- T4: `BusDataSelect` = rb, `e_Z` = 1.
- T5: `BusDataSelect` = Zlow, `e_LO` = 1.
- T6: `BusDataSelect` = Zhigh, `e_HI` = 1, `done` = 1.
REQ-015 Fetch-to-done latency SHALL be 6 cycles for three-operand ops, 7 for MUL/DIV and 4 for illegal ops.
REQ-016 After the done state, the sequencer SHALL go to T0 if `run` = 1 and to IDLE otherwise; `run` SHALL be sampled only in IDLE and in done states.
REQ-017 Deasserting `run` mid-instruction SHALL NOT abort the instruction.
REQ-018 At most one of `e_GP`, `e_LO`, `e_HI`, `e_PC` SHALL be asserted in any cycle.
REQ-019 `busy` SHALL be 1 in every state except IDLE.

Reset
REQ-020 `clear` = 1 SHALL force IDLE immediately, independent of `clock`, including mid-instruction.
REQ-021 During reset, all enables, `incPC`, `MDR_read`, `done`, `busy` and `illegal` SHALL be 0, and `BusDataSelect`, `GP_addr` and `ALU_op` SHALL be 0.
REQ-022 `illegal` SHALL clear only on reset.

Configuration
REQ-023 With `SEQ_SINGLE_STEP_EN` defined, input `step` (1 bit) SHALL exist, and every state transition except those out of IDLE SHALL additionally require `step` = 1 on that clock edge.
REQ-024 With `SEQ_SINGLE_STEP_EN` undefined, the `step` port SHALL be absent and transitions SHALL occur every cycle.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset, then `run` = 1, IR = DIV (opcode 5'b00110, ra = 2, rb = 6) -> states T0-T6 on consecutive cycles; T3 select 2, T4 select 6 with `ALU_op` 0110, T5 `e_LO`, T6 `e_HI` with `done` = 1.
- IR = ADD (opcode 5'b00011, ra = 1, rb = 2, rc = 3) -> T5 select 5'b10011 with `GP_addr` 1 and `e_GP` = 1, `done` in T5, no T6.
- `run` held 1 across two instructions -> T0 immediately follows the done state with no IDLE cycle; `run` = 0 at the done state -> IDLE, `busy` = 0.
- `clear` pulsed mid-T4 -> IDLE and all outputs 0 before the next clock edge.
- IR = 32'h80000000 -> `illegal` = 1 at T3, `done` in T3, no enables; `illegal` stays 1 until `clear`.
- `SEQ_SINGLE_STEP_EN` defined, `step` = 0 -> state frozen in T1; one `step` pulse -> exactly one advance to T2.
